// File: rtl/hvac_pkg.sv
// Shared FSM state, {I1..I4} request encodings and last-mode type for the thermostat requester.
// Latency: none (types and constants only). Backpressure: none.
// The optional sensor-timeout fault in the top is enabled by HVAC_TREQ_FAULT_EN.
package hvac_pkg;

    typedef enum logic [1:0] {
        S_OFF,
        S_IDLE,
        S_HEAT,
        S_COOL
    } state_t;

    typedef enum logic [1:0] {
        LM_NONE,
        LM_HEAT,
        LM_COOL
    } last_mode_t;

    localparam logic [3:0] ENC_OFF  = 4'b0011;
    localparam logic [3:0] ENC_IDLE = 4'b1000;
    localparam logic [3:0] ENC_HEAT = 4'b1100;
    localparam logic [3:0] ENC_COOL = 4'b1010;

    function automatic logic [3:0] state_enc(input state_t s);
        case (s)
            S_OFF:   state_enc = ENC_OFF;
            S_IDLE:  state_enc = ENC_IDLE;
            S_HEAT:  state_enc = ENC_HEAT;
            S_COOL:  state_enc = ENC_COOL;
            default: state_enc = ENC_OFF;
        endcase
    endfunction

endpackage

// File: rtl/hvac_band_qual.sv
// Band compare plus saturating confirm counter; COLD selects below-band, else above-band.
// Latency: qual rises the cycle after the CONFIRM-th consecutive qualifying valid sample.
// Backpressure: none; counter holds on cycles without temp_valid, clr wins over counting.
module hvac_band_qual #(
    parameter int CONFIRM = 3,
    parameter bit COLD    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] temp,
    input  logic       temp_valid,
    input  logic [7:0] setpoint,
    input  logic [3:0] hyst,
    input  logic       at_sp,
    input  logic       clr,
    output logic       qual
);

    localparam int CW = $clog2(CONFIRM + 1);

    logic [8:0]    lo9;
    logic [8:0]    hi9;
    logic [7:0]    lo;
    logic [7:0]    hi;
    logic          cond;
    logic [CW-1:0] cnt;

    // 9-bit arithmetic so the band edges saturate at 0 and 255 instead of wrapping.
    assign lo9 = {1'b0, setpoint} - {5'b0, hyst};
    assign hi9 = {1'b0, setpoint} + {5'b0, hyst};
    assign lo  = lo9[8] ? 8'd0  : lo9[7:0];
    assign hi  = hi9[8] ? 8'hff : hi9[7:0];

    // at_sp switches to the inclusive setpoint test used to leave an active mode.
    always_comb begin
        cond = 1'b0;
        if (COLD) cond = at_sp ? (temp <= setpoint) : (temp < lo);
        else      cond = at_sp ? (temp >= setpoint) : (temp > hi);
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (temp_valid) begin
            if (!cond)                     cnt <= '0;
            else if (cnt != CW'(CONFIRM))  cnt <= cnt + 1'b1;
        end
    end

    assign qual = (cnt == CW'(CONFIRM));

endmodule

// File: rtl/hvac_thermostat_req.sv
// Thermostat FSM producing registered {I1..I4} mode requests (OFF/IDLE/HEAT/COOL).
// Latency: outputs update on the edge after the transition decision. Backpressure: none.
// HVAC_TREQ_FAULT_EN adds a sticky sensor-timeout fault output that forces OFF.
module hvac_thermostat_req
    import hvac_pkg::*;
#(
    parameter int CONFIRM  = 3,
    parameter int MIN_IDLE = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] temp,
    input  logic       temp_valid,
    input  logic [7:0] setpoint,
    input  logic [3:0] hyst,
    input  logic       sys_on,
    input  logic       shutdown,
    output logic       I1,
    output logic       I2,
    output logic       I3,
    output logic       I4
`ifdef HVAC_TREQ_FAULT_EN
    ,
    output logic       fault
`endif
);

    localparam int IW = $clog2(MIN_IDLE + 1);

    state_t        state;
    state_t        state_nxt;
    last_mode_t    last_mode;
    logic [IW-1:0] idle_cnt;
    logic [3:0]    mode_bits;
    logic          cold_q;
    logic          hot_q;
    logic          state_chg;
    logic          force_off;
    logic          idle_done;

    assign state_chg = (state_nxt != state);
    assign idle_done = (idle_cnt >= IW'(MIN_IDLE));

    // Cold side doubles as the COOL exit counter, hot side as the HEAT exit counter.
    hvac_band_qual #(.CONFIRM(CONFIRM), .COLD(1'b1)) u_cold (
        .clk        (clk),
        .reset      (reset),
        .temp       (temp),
        .temp_valid (temp_valid),
        .setpoint   (setpoint),
        .hyst       (hyst),
        .at_sp      (state == S_COOL),
        .clr        (state_chg),
        .qual       (cold_q)
    );

    hvac_band_qual #(.CONFIRM(CONFIRM), .COLD(1'b0)) u_hot (
        .clk        (clk),
        .reset      (reset),
        .temp       (temp),
        .temp_valid (temp_valid),
        .setpoint   (setpoint),
        .hyst       (hyst),
        .at_sp      (state == S_HEAT),
        .clr        (state_chg),
        .qual       (hot_q)
    );

`ifdef HVAC_TREQ_FAULT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] stall_cnt;
    logic          seen_valid;
    logic          timeout_hit;

    assign timeout_hit = !temp_valid && (stall_cnt == TW'(TIMEOUT - 1));

    // Fault clears only once the sensor has been heard from again and the user drops sys_on.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            fault      <= 1'b0;
            seen_valid <= 1'b0;
        end else begin
            if (temp_valid)                  stall_cnt <= '0;
            else if (stall_cnt != TW'(TIMEOUT)) stall_cnt <= stall_cnt + 1'b1;

            if (timeout_hit) begin
                fault      <= 1'b1;
                seen_valid <= 1'b0;
            end else if (fault) begin
                if (temp_valid) seen_valid <= 1'b1;
                if (!sys_on && seen_valid) begin
                    fault      <= 1'b0;
                    seen_valid <= 1'b0;
                end
            end
        end
    end

    assign force_off = shutdown || !sys_on || fault || timeout_hit;
`else
    assign force_off = shutdown || !sys_on;
`endif

    always_comb begin
        state_nxt = state;
        if (force_off) begin
            state_nxt = S_OFF;
        end else begin
            case (state)
                S_OFF:  state_nxt = S_IDLE;
                S_IDLE: begin
                    // Heat wins a simultaneous cold/hot qualification.
                    if (cold_q && (last_mode != LM_COOL || idle_done))     state_nxt = S_HEAT;
                    else if (hot_q && (last_mode != LM_HEAT || idle_done)) state_nxt = S_COOL;
                end
                S_HEAT: if (hot_q)  state_nxt = S_IDLE;
                S_COOL: if (cold_q) state_nxt = S_IDLE;
                default: state_nxt = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_OFF;
            mode_bits <= ENC_OFF;
            last_mode <= LM_NONE;
            idle_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            mode_bits <= state_enc(state_nxt);

            if (state == S_HEAT && state_nxt == S_IDLE)      last_mode <= LM_HEAT;
            else if (state == S_COOL && state_nxt == S_IDLE) last_mode <= LM_COOL;

            if (state != S_IDLE && state_nxt == S_IDLE)          idle_cnt <= '0;
            else if (state == S_IDLE && idle_cnt != IW'(MIN_IDLE)) idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign {I1, I2, I3, I4} = mode_bits;

endmodule

// File: tb/tb_hvac_thermostat_req.sv
// Bench for hvac_thermostat_req: directed scenarios plus random traffic against a rule-level model.
// Latency: checks sample 1 time unit after each rising edge. Backpressure: none.
// Define HVAC_TREQ_FAULT_EN to exercise the sensor-timeout fault path.
module tb_hvac_thermostat_req;

    localparam int CONFIRM  = 3;
    localparam int MIN_IDLE = 16;
    localparam int TIMEOUT  = 1024;

    localparam logic [3:0] E_OFF  = 4'b0011;
    localparam logic [3:0] E_IDLE = 4'b1000;
    localparam logic [3:0] E_HEAT = 4'b1100;
    localparam logic [3:0] E_COOL = 4'b1010;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] temp;
    logic       temp_valid;
    logic [7:0] setpoint;
    logic [3:0] hyst;
    logic       sys_on;
    logic       shutdown;
    logic       I1, I2, I3, I4;
    logic [3:0] outs;
`ifdef HVAC_TREQ_FAULT_EN
    logic       fault;
`endif

    int checks  = 0;
    int passed  = 0;
    int illegal = 0;
    bit started = 1'b0;

    // Reference model: mode 0=OFF 1=IDLE 2=HEAT 3=COOL, last 0=none 2=heat 3=cool.
    int m_mode, m_cold, m_hot, m_idle, m_last, m_stall;
    bit m_fault, m_seen;

    always #5 clk = ~clk;

    assign outs = {I1, I2, I3, I4};

    hvac_thermostat_req #(
        .CONFIRM  (CONFIRM),
        .MIN_IDLE (MIN_IDLE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .temp       (temp),
        .temp_valid (temp_valid),
        .setpoint   (setpoint),
        .hyst       (hyst),
        .sys_on     (sys_on),
        .shutdown   (shutdown),
        .I1         (I1),
        .I2         (I2),
        .I3         (I3),
        .I4         (I4)
`ifdef HVAC_TREQ_FAULT_EN
        ,
        .fault      (fault)
`endif
    );

    always @(negedge clk)
        if (started && outs !== E_OFF && outs !== E_IDLE && outs !== E_HEAT && outs !== E_COOL)
            illegal++;

    function automatic logic [3:0] mode_code(input int m);
        case (m)
            0:       return E_OFF;
            1:       return E_IDLE;
            2:       return E_HEAT;
            default: return E_COOL;
        endcase
    endfunction

    task automatic model_step();
        int lo, hi, nxt;
        bit off, timed_out, cold_ready, hot_ready, cold_now, hot_now;
        if (reset) begin
            m_mode = 0; m_cold = 0; m_hot = 0; m_idle = 0; m_last = 0;
            m_stall = 0; m_fault = 0; m_seen = 0;
            return;
        end
        lo = int'(setpoint) - int'(hyst);
        if (lo < 0) lo = 0;
        hi = int'(setpoint) + int'(hyst);
        if (hi > 255) hi = 255;
        cold_ready = (m_cold >= CONFIRM);
        hot_ready  = (m_hot >= CONFIRM);
        timed_out  = 1'b0;
`ifdef HVAC_TREQ_FAULT_EN
        timed_out = !temp_valid && (m_stall == TIMEOUT - 1);
`endif
        off = shutdown || !sys_on || m_fault || timed_out;
        nxt = m_mode;
        if (off) nxt = 0;
        else if (m_mode == 0) nxt = 1;
        else if (m_mode == 1) begin
            if (cold_ready && (m_last != 3 || m_idle >= MIN_IDLE))     nxt = 2;
            else if (hot_ready && (m_last != 2 || m_idle >= MIN_IDLE)) nxt = 3;
        end else if (m_mode == 2 && hot_ready) nxt = 1;
        else if (m_mode == 3 && cold_ready) nxt = 1;

        cold_now = (m_mode == 3) ? (temp <= setpoint) : (int'(temp) < lo);
        hot_now  = (m_mode == 2) ? (temp >= setpoint) : (int'(temp) > hi);
        if (nxt != m_mode) begin
            m_cold = 0; m_hot = 0;
        end else if (temp_valid) begin
            m_cold = cold_now ? ((m_cold + 1 > CONFIRM) ? CONFIRM : m_cold + 1) : 0;
            m_hot  = hot_now  ? ((m_hot + 1 > CONFIRM)  ? CONFIRM : m_hot + 1)  : 0;
        end
        if (nxt == 1 && m_mode != 1) m_idle = 0;
        else if (m_mode == 1 && m_idle < MIN_IDLE) m_idle++;
        if (nxt == 1 && (m_mode == 2 || m_mode == 3)) m_last = m_mode;

        if (temp_valid) m_stall = 0;
        else if (m_stall < TIMEOUT) m_stall++;
        if (timed_out) begin
            m_fault = 1; m_seen = 0;
        end else if (m_fault) begin
            if (!sys_on && m_seen) begin
                m_fault = 0; m_seen = 0;
            end else if (temp_valid) m_seen = 1;
        end
        m_mode = nxt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; sys_on = 1; shutdown = 0; temp_valid = 0;
        temp = 8'd100; setpoint = 8'd100; hyst = 4'd4;
        tick(); tick();
        started = 1'b1;
        checks++;
        if (outs !== E_OFF) $display("FAIL reset_state: got %b expected %b", outs, E_OFF);
        else passed++;
`ifdef HVAC_TREQ_FAULT_EN
        checks++;
        if (fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", fault);
        else passed++;
`endif
        reset = 0;
        tick();
        checks++;
        if (outs !== E_IDLE) $display("FAIL reset_to_idle: got %b expected %b", outs, E_IDLE);
        else passed++;
    endtask

    task automatic test_heat();
        temp = 8'd90; temp_valid = 1;
        repeat (3) tick();
        checks++;
        if (outs !== E_IDLE) $display("FAIL heat_not_early: got %b expected %b", outs, E_IDLE);
        else passed++;
        temp_valid = 0;
        tick();
        checks++;
        if (outs !== E_HEAT) $display("FAIL heat_entry: got %b expected %b", outs, E_HEAT);
        else passed++;
        temp = 8'd100; temp_valid = 1;
        repeat (3) tick();
        checks++;
        if (outs !== E_HEAT) $display("FAIL heat_hold: got %b expected %b", outs, E_HEAT);
        else passed++;
        temp_valid = 0;
        tick();
        checks++;
        if (outs !== E_IDLE) $display("FAIL heat_exit: got %b expected %b", outs, E_IDLE);
        else passed++;
    endtask

    task automatic test_lockout();
        temp = 8'd110;
        for (int k = 1; k <= MIN_IDLE; k++) begin
            temp_valid = (k <= 3);
            tick();
            checks++;
            if (outs !== E_IDLE) $display("FAIL lockout_hold[%0d]: got %b expected %b", k, outs, E_IDLE);
            else passed++;
        end
        temp_valid = 0;
        tick();
        checks++;
        if (outs !== E_COOL) $display("FAIL lockout_release: got %b expected %b", outs, E_COOL);
        else passed++;
    endtask

    task automatic test_shutdown();
        shutdown = 1;
        tick();
        checks++;
        if (outs !== E_OFF) $display("FAIL shutdown_off: got %b expected %b", outs, E_OFF);
        else passed++;
        shutdown = 0;
        tick();
        checks++;
        if (outs !== E_IDLE) $display("FAIL shutdown_resume: got %b expected %b", outs, E_IDLE);
        else passed++;
    endtask

    task automatic test_counter_clear();
        logic [7:0] seq [5];
        seq = '{8'd90, 8'd90, 8'd97, 8'd90, 8'd90};
        temp_valid = 1;
        for (int k = 0; k < 5; k++) begin
            temp = seq[k];
            tick();
        end
        temp_valid = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (outs !== E_IDLE) $display("FAIL clear_no_heat[%0d]: got %b expected %b", k, outs, E_IDLE);
            else passed++;
        end
        temp = 8'd90; temp_valid = 1;
        tick();
        temp_valid = 0;
        tick();
        checks++;
        if (outs !== E_HEAT) $display("FAIL clear_then_heat: got %b expected %b", outs, E_HEAT);
        else passed++;
        temp = 8'd100; temp_valid = 1;
        repeat (3) tick();
        temp_valid = 0;
        tick();
        checks++;
        if (outs !== E_IDLE) $display("FAIL clear_back_idle: got %b expected %b", outs, E_IDLE);
        else passed++;
    endtask

    task automatic test_stall();
`ifdef HVAC_TREQ_FAULT_EN
        temp = 8'd100; temp_valid = 1;
        tick();
        temp_valid = 0;
        repeat (TIMEOUT - 1) tick();
        checks++;
        if (fault !== 1'b0 || outs !== E_IDLE)
            $display("FAIL stall_pre_timeout: got fault=%b mode=%b expected fault=0 mode=%b", fault, outs, E_IDLE);
        else passed++;
        tick();
        checks++;
        if (fault !== 1'b1 || outs !== E_OFF)
            $display("FAIL stall_timeout: got fault=%b mode=%b expected fault=1 mode=%b", fault, outs, E_OFF);
        else passed++;
        temp_valid = 1;
        tick();
        temp_valid = 0;
        checks++;
        if (fault !== 1'b1 || outs !== E_OFF)
            $display("FAIL fault_sticky: got fault=%b mode=%b expected fault=1 mode=%b", fault, outs, E_OFF);
        else passed++;
        sys_on = 0;
        tick();
        checks++;
        if (fault !== 1'b0) $display("FAIL fault_clear: got %b expected 0", fault);
        else passed++;
        sys_on = 1;
        tick();
        checks++;
        if (outs !== E_IDLE) $display("FAIL fault_recover: got %b expected %b", outs, E_IDLE);
        else passed++;
`else
        int bad;
        bad = 0;
        temp = 8'd90; temp_valid = 1;
        repeat (3) tick();
        temp_valid = 0;
        tick();
        repeat (TIMEOUT + 76) begin
            tick();
            if (outs !== E_HEAT) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL stall_hold: got %0d cycles off HEAT expected 0", bad);
        else passed++;
        temp = 8'd100; temp_valid = 1;
        repeat (3) tick();
        temp_valid = 0;
        tick();
        checks++;
        if (outs !== E_IDLE) $display("FAIL stall_exit: got %b expected %b", outs, E_IDLE);
        else passed++;
`endif
    endtask

    task automatic test_random();
        int t;
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            sys_on   = ($urandom_range(0, 49) != 0);
            shutdown = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 63) == 0) begin
                case ($urandom_range(0, 3))
                    0:       setpoint = 8'($urandom_range(0, 5));
                    1:       setpoint = 8'($urandom_range(250, 255));
                    default: setpoint = 8'($urandom_range(60, 200));
                endcase
                hyst = 4'($urandom_range(0, 15));
            end
            temp_valid = 1'($urandom_range(0, 1));
            t = int'(setpoint) + int'($urandom_range(0, 40)) - 20;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            temp = 8'(t);
            tick();
            checks++;
            if (outs !== mode_code(m_mode))
                $display("FAIL random_mode[%0d]: got %b expected %b", i, outs, mode_code(m_mode));
            else passed++;
`ifdef HVAC_TREQ_FAULT_EN
            checks++;
            if (fault !== m_fault) $display("FAIL random_fault[%0d]: got %b expected %b", i, fault, m_fault);
            else passed++;
`endif
        end
        checks++;
        if (illegal != 0) $display("FAIL illegal_encoding: got %0d illegal cycles expected 0", illegal);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_heat();
        test_lockout();
        test_shutdown();
        test_counter_clear();
        test_stall();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
